bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter, downstream of the 16-bit 2:1 display mux.
//   Converts the selected 16-bit value to 5 packed BCD digits for the seven-segment decoders.
//   Uses iterative shift-add-3 (double dabble): 1 bit per clock, 1 shared adjust/shift datapath.
//   Start/done handshake; result held stable between conversions.
// PARAMETERS
//   WIDTH   16  binary input width; also the number of shift iterations
//   DIGITS  5   BCD digits produced; must satisfy 10**DIGITS > 2**WIDTH - 1
// PORTS
//   clk      in   1           system clock, all state changes on rising edge
//   reset    in   1           synchronous, active-high reset
//   start    in   1           request conversion of bin_in; sampled only in IDLE
//   bin_in   in   WIDTH       unsigned binary value (mux_out of the display mux)
//   busy     out  1           1 while a conversion is in progress (state != IDLE)
//   done     out  1           1-cycle pulse: bcd_out updated with a new result
//   bcd_out  out  4*DIGITS    packed BCD; [3:0] = ones digit, [4*DIGITS-1 -:4] = most significant digit
// BEHAVIOUR
//   Reset (reset=1 at an edge): state=IDLE, busy=0, done=0, bcd_out=0, internal regs=0.
//     Applies from any state, including mid-conversion; the partial result is discarded
//     and bcd_out is not updated.
//   States: IDLE, SHIFT.
//   IDLE: busy=0. If start=1 at edge E0: capture bin_in into shift reg, clear BCD
//     scratch, cnt=0, go to SHIFT. bin_in is not sampled again until the next start.
//   SHIFT: busy=1. At each edge, in this order:
//     (1) any scratch digit >= 5 gets +3, 4-bit digit math, no carry between digits;
//     (2) shift {scratch, shift reg} left by 1;
//     (3) cnt++.
//     The edge with cnt==WIDTH-1 does the final iteration, loads bcd_out with the
//     result, sets done=1, and goes to IDLE.
//   Latency: start sampled at E0 -> bcd_out valid and done=1 after edge E(WIDTH).
//     Default: E16, i.e. 16 cycles after capture.
//   done is high for exactly 1 cycle; otherwise 0. bcd_out changes only on a done edge.
//   start while busy=1: ignored. No queuing, no effect on the current conversion.
//   start=1 in the cycle done=1 (state already IDLE): accepted.
//     Back-to-back throughput = WIDTH+1 cycles per result.
//   start held high continuously: converts repeatedly, resampling bin_in on each
//     IDLE edge.
//   Full-scale input: 2**WIDTH-1 converts without overflow, given the DIGITS rule.
//   cnt width: $clog2(WIDTH); no wrap beyond WIDTH-1 is permitted.
// TESTING
//   1. Assert reset 2 cycles mid-run -> busy=0, done=0, bcd_out=20'h00000 on the next cycle.
//   2. bin_in=16'h0000, pulse start -> done exactly 16 cycles later, bcd_out=20'h00000.
//   3. bin_in=16'hA5A5 (42405) -> bcd_out=20'h42405; then bin_in=16'h5A5A (23130)
//      -> bcd_out=20'h23130.
//   4. bin_in=16'hFFFF -> bcd_out=20'h65535. Set bin_in=16'h0001 at cycle 3 of the
//      conversion: result unchanged.
//   5. Start at cycles 0 and 5 (bin_in 1234 then 9999) -> one done, bcd_out=20'h01234.
//      Second start ignored, busy stays 1.
//   6. Reset at cycle 8 of a 16'h1234 conversion, then start with 16'h0042 -> no done
//      for the aborted run; bcd_out=20'h00066 after 16 cycles.
//   Bench: compare every result with a behavioural div/mod-10 model; use
//   assert ... else $error; finish with $stop.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// A single adjust/shift datapath is reused for WIDTH iterations. The result
// is loaded into bcd_out, and done pulses for one cycle, only when a
// conversion completes.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  shreg, shreg_nx;
  logic [BW-1:0]     scratch, scratch_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [BW-1:0]     bcd_nx;
  logic              done_nx;

  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] shifted;

  // Shared datapath: add 3 to every digit >= 5, then shift {scratch, shreg} left by one
  always_comb begin
    adj = scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    shifted = {adj, shreg} << 1;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      scratch <= scratch_nx;
      cnt     <= cnt_nx;
      bcd_out <= bcd_nx;
      done    <= done_nx;
    end
  end

  // Next-state and next-value logic; holds everything by default
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    scratch_nx = scratch;
    cnt_nx     = cnt;
    bcd_nx     = bcd_out;
    done_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          shreg_nx   = bin_in;
          scratch_nx = '0;
          cnt_nx     = '0;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_nx = shifted[BW+WIDTH-1:WIDTH];
        shreg_nx   = shifted[WIDTH-1:0];
        cnt_nx     = cnt + 1'b1;
        if (cnt == LAST) begin
          // Final iteration: publish the shifted scratch and return the counter to 0
          bcd_nx   = shifted[BW+WIDTH-1:WIDTH];
          done_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected BCD results
// (computed with div/mod 10) and the cycle in which done is due; a monitor pops
// and compares whenever done is seen.
module tb_bin_to_bcd_seq;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned LAT    = WIDTH + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*DIGITS-1:0] val;
    int unsigned         when;
  } exp_t;

  exp_t                sb[$];
  logic [4*DIGITS-1:0] last_exp = '0;
  int unsigned         cyc = 0;
  int unsigned         total = 0;
  int unsigned         bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits by repeated div/mod 10
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned         x;
    r = '0;
    x = v;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: compare on every done, otherwise bcd_out must hold the last result
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() > 0 && cyc > sb[0].when) begin
        chk("missing_done", 32'(cyc), 32'(sb[0].when));
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bcd_result", 32'(bcd_out), 32'(e.val));
          chk("done_latency", 32'(cyc), 32'(e.when));
          last_exp = e.val;
        end
      end else begin
        chk("bcd_hold", 32'(bcd_out), 32'(last_exp));
      end
    end
  end

  // Drive start for the edge after the current cycle and record the expectation
  task automatic issue(input logic [WIDTH-1:0] v);
    exp_t e;
    bin_in = v;
    start  = 1'b1;
    e.val  = ref_bcd(32'(v));
    e.when = cyc + LAT;
    sb.push_back(e);
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() > 0 && n < 4 * LAT) begin
      @(posedge clk) #1;
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk) #1;
  endtask

  task automatic do_reset(input int unsigned n);
    sb.delete();
    last_exp = '0;
    reset = 1'b1;
    start = 1'b0;
    repeat (n) @(posedge clk) #1;
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    @(posedge clk) #1;
    do_reset(2);

    // Reset mid-run discards the conversion
    issue(16'd4321);
    repeat (4) @(posedge clk) #1;
    do_reset(2);
    repeat (20) @(posedge clk) #1;

    // Zero, and the two mirrored patterns
    issue(16'h0000); drain();
    issue(16'hA5A5); drain();
    chk("a5a5_value", 32'(last_exp), 32'h42405);
    issue(16'h5A5A); drain();
    chk("5a5a_value", 32'(last_exp), 32'h23130);

    // Full scale; bin_in changing mid-conversion has no effect
    issue(16'hFFFF);
    repeat (2) @(posedge clk) #1;
    bin_in = 16'h0001;
    drain();
    chk("ffff_value", 32'(last_exp), 32'h65535);

    // Start while busy is ignored
    issue(16'd1234);
    repeat (4) @(posedge clk) #1;
    bin_in = 16'd9999;
    start  = 1'b1;
    @(posedge clk) #1;
    start  = 1'b0;
    chk("busy_held", 32'(busy), 32'd1);
    drain();
    chk("ignored_start", 32'(busy), 32'd0);

    // Reset at cycle 8 of a conversion, then a fresh one
    issue(16'h1234);
    repeat (7) @(posedge clk) #1;
    do_reset(1);
    issue(16'h0042); drain();
    chk("after_abort", 32'(last_exp), 32'h00066);

    // start held high: back-to-back conversions every WIDTH+1 cycles
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      v      = 16'($urandom);
      bin_in = v;
      start  = 1'b1;
      e.val  = ref_bcd(32'(v));
      e.when = cyc + LAT;
      sb.push_back(e);
      repeat (LAT) @(posedge clk) #1;
    end
    start = 1'b0;
    drain();

    // Random single conversions with random gaps
    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom);
      issue(v);
      drain();
      repeat ($urandom_range(0, 3)) @(posedge clk) #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    bad++;
    $display("FAIL global_timeout: cycle=%0d limit=20000", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
